// File: rtl/ttc_gen_pkg.sv
// rtl/ttc_gen_pkg.sv - shared types and widths for the local TTC command generator
package ttc_gen_pkg;
    localparam int BXN_W         = 12;
    localparam int ORBIT_W       = 32;
    localparam int L1A_CNT_W     = 24;
    localparam int ORBIT_LEN_DEF = 3564;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;
endpackage

// File: rtl/ttc_l1a_seq.sv
// rtl/ttc_l1a_seq.sv - periodic L1A sequencer: period counter, remaining count, busy flag
module ttc_l1a_seq
    import ttc_gen_pkg::*;
#(
    parameter int MIN_PERIOD = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] period,
    input  logic [15:0] count,
    output logic        l1a,
    output logic        busy
);
    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    logic [15:0] per_eff;
    logic [15:0] per_q;
    logic [15:0] cnt;
    logic [15:0] rem;
    logic        unlimited;
    logic        fire;

    assign per_eff = (period < MIN_P) ? MIN_P : period;
    // cnt holds clocks elapsed since the start pulse or the last L1A
    assign fire    = busy && run && !stop && (cnt == per_q - 16'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l1a       <= 1'b0;
            busy      <= 1'b0;
            per_q     <= MIN_P;
            cnt       <= '0;
            rem       <= '0;
            unlimited <= 1'b0;
        end else begin
            l1a <= fire;
            if (!run || stop) begin
                busy <= 1'b0;
            end else if (start) begin
                busy      <= 1'b1;
                per_q     <= per_eff;
                cnt       <= 16'd1;
                rem       <= count;
                unlimited <= (count == 16'd0);
            end else if (fire) begin
                cnt <= '0;
                if (!unlimited) begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1)
                        busy <= 1'b0;
                end
            end else if (busy) begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/ttc_gen.sv
// rtl/ttc_gen.sv - local TTC generator (bx0, resync, L1A train); TTC_GEN_L1A_EN builds the L1A path
module ttc_gen
    import ttc_gen_pkg::*;
#(
    parameter int ORBIT_LEN      = ORBIT_LEN_DEF,
    parameter int BX0_BX         = 0,
    parameter int L1A_MIN_PERIOD = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 resync_req,
    output logic                 resync_ack,
    input  logic                 l1a_start,
    input  logic                 l1a_stop,
    input  logic [15:0]          l1a_period,
    input  logic [15:0]          l1a_count,
    output logic                 ttc_bx0,
    output logic                 ttc_resync,
    output logic                 ttc_l1a,
    output logic                 l1a_busy,
    output logic [BXN_W-1:0]     bxn,
    output logic [ORBIT_W-1:0]   orbit_cnt,
    output logic [L1A_CNT_W-1:0] l1a_sent
);
    localparam logic [BXN_W-1:0] BXN_LAST = BXN_W'(ORBIT_LEN - 1);
    localparam logic [BXN_W-1:0] BX0_POS  = BXN_W'(BX0_BX);

    state_t           state, state_nx;
    logic             resync_prev;
    logic             resync_edge;
    logic [BXN_W-1:0] bxn_nx;
    logic             wrap;
    logic             seq_run;

    assign resync_edge = resync_req & ~resync_prev;
    assign seq_run     = (state == RUN) && (state_nx == RUN);

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     if (resync_edge) state_nx = RESYNC;
                RESYNC:  state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Entering RUN from IDLE or RESYNC starts a fresh orbit at 0 without counting a wrap
    always_comb begin
        bxn_nx = '0;
        wrap   = 1'b0;
        case (state_nx)
            RESYNC: bxn_nx = BXN_LAST;
            RUN: begin
                if (state == RUN) begin
                    if (bxn == BXN_LAST)
                        wrap = 1'b1;
                    else
                        bxn_nx = bxn + 1'b1;
                end
            end
            default: bxn_nx = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            resync_prev <= 1'b0;
            bxn         <= '0;
            orbit_cnt   <= '0;
            ttc_bx0     <= 1'b0;
            ttc_resync  <= 1'b0;
            resync_ack  <= 1'b0;
        end else begin
            state       <= state_nx;
            resync_prev <= resync_req;
            bxn         <= bxn_nx;
            ttc_bx0     <= (state_nx == RUN) && (bxn_nx == BX0_POS);
            ttc_resync  <= (state_nx == RESYNC);
            resync_ack  <= (state_nx == RESYNC);
            if (state_nx == RESYNC)
                orbit_cnt <= '0;
            else if (wrap)
                orbit_cnt <= orbit_cnt + 1'b1;
        end
    end

`ifdef TTC_GEN_L1A_EN
    ttc_l1a_seq #(
        .MIN_PERIOD (L1A_MIN_PERIOD)
    ) u_seq (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (seq_run),
        .start   (l1a_start),
        .stop    (l1a_stop),
        .period  (l1a_period),
        .count   (l1a_count),
        .l1a     (ttc_l1a),
        .busy    (l1a_busy)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            l1a_sent <= '0;
        else if (ttc_l1a && (l1a_sent != '1))
            l1a_sent <= l1a_sent + 1'b1;
    end
`else
    logic unused_l1a;
    assign unused_l1a = &{1'b0, l1a_start, l1a_stop, l1a_period, l1a_count, seq_run};
    assign ttc_l1a    = 1'b0;
    assign l1a_busy   = 1'b0;
    assign l1a_sent   = '0;
`endif
endmodule

// File: tb/tb_ttc_gen.sv
// tb/tb_ttc_gen.sv - directed self-checking bench for ttc_gen
module tb_ttc_gen;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable, resync_req, resync_ack;
    logic        l1a_start, l1a_stop;
    logic [15:0] l1a_period, l1a_count;
    logic        ttc_bx0, ttc_resync, ttc_l1a, l1a_busy;
    logic [11:0] bxn;
    logic [31:0] orbit_cnt;
    logic [23:0] l1a_sent;

    int tests = 0;
    int fails = 0;

    ttc_gen dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .resync_req (resync_req),
        .resync_ack (resync_ack),
        .l1a_start  (l1a_start),
        .l1a_stop   (l1a_stop),
        .l1a_period (l1a_period),
        .l1a_count  (l1a_count),
        .ttc_bx0    (ttc_bx0),
        .ttc_resync (ttc_resync),
        .ttc_l1a    (ttc_l1a),
        .l1a_busy   (l1a_busy),
        .bxn        (bxn),
        .orbit_cnt  (orbit_cnt),
        .l1a_sent   (l1a_sent)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n_bx0, n_res, n_ack, n_l1a, off;
        reset_n = 1'b0; enable = 1'b0; resync_req = 1'b0;
        l1a_start = 1'b0; l1a_stop = 1'b0; l1a_period = 16'd0; l1a_count = 16'd0;
        step(); step();
        check("rst_bxn", bxn, 0);
        check("rst_orbit", orbit_cnt, 0);
        check("rst_bx0", ttc_bx0, 0);
        check("rst_resync", ttc_resync, 0);
        check("rst_ack", resync_ack, 0);
        check("rst_l1a", ttc_l1a, 0);
        check("rst_busy", l1a_busy, 0);
        check("rst_sent", l1a_sent, 0);
        reset_n = 1'b1;
        step();
        check("idle_bxn", bxn, 0);

        // Two orbits from enable
        enable = 1'b1;
        step();
        check("run_c1_bx0", ttc_bx0, 1);
        check("run_c1_bxn", bxn, 0);
        n_bx0 = 1;
        for (int c = 2; c <= 7129; c++) begin
            step();
            if (ttc_bx0) n_bx0++;
            if (c == 2)    check("run_c2_bxn", bxn, 1);
            if (c == 3564) check("run_c3564_bxn", bxn, 3563);
            if (c == 3564) check("run_c3564_orbit", orbit_cnt, 0);
            if (c == 3565) check("run_c3565_bx0", ttc_bx0, 1);
            if (c == 3565) check("run_c3565_orbit", orbit_cnt, 1);
        end
        check("run_c7129_bxn", bxn, 0);
        check("run_orbit2", orbit_cnt, 2);
        check("run_bx0_count", n_bx0, 3);

        // Resync at bxn 1000, request held for 10 cycles
        for (int c = 0; c < 1000; c++) step();
        check("pre_resync_bxn", bxn, 1000);
        resync_req = 1'b1;
        n_res = 0; n_ack = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ttc_resync) n_res++;
            if (resync_ack) n_ack++;
            if (c == 0) begin
                check("rs_strobe", ttc_resync, 1);
                check("rs_bxn", bxn, 3563);
                check("rs_bx0", ttc_bx0, 0);
            end
            if (c == 1) begin
                check("rs_next_bxn", bxn, 0);
                check("rs_next_bx0", ttc_bx0, 1);
                check("rs_next_orbit", orbit_cnt, 0);
            end
        end
        check("rs_count", n_res, 1);
        check("rs_ack_count", n_ack, 1);
        resync_req = 1'b0;
        step();
        resync_req = 1'b1;
        step();
        check("rs_rearm", ttc_resync, 1);
        resync_req = 1'b0;
        step();

`ifdef TTC_GEN_L1A_EN
        // Finite train: 5 L1As every 100 clocks
        l1a_period = 16'd100; l1a_count = 16'd5;
        l1a_start = 1'b1;
        step();
        l1a_start = 1'b0;
        check("l1a_busy_n1", l1a_busy, 1);
        n_l1a = 0;
        for (off = 2; off <= 520; off++) begin
            step();
            if (ttc_l1a) begin
                n_l1a++;
                check("l1a_pos", off, 100 * n_l1a);
            end
            if (off == 499) check("l1a_busy_499", l1a_busy, 1);
            if (off == 500) check("l1a_busy_500", l1a_busy, 0);
        end
        check("l1a_n5", n_l1a, 5);
        check("l1a_sent5", l1a_sent, 5);

        // Start and stop together: stop wins
        l1a_start = 1'b1; l1a_stop = 1'b1;
        step();
        l1a_start = 1'b0; l1a_stop = 1'b0;
        check("l1a_stopwins", l1a_busy, 0);

        // Period clamped to 4, unlimited, then an L1A due in the RESYNC cycle
        l1a_period = 16'd1; l1a_count = 16'd0;
        l1a_start = 1'b1;
        step();
        l1a_start = 1'b0;
        n_l1a = 0;
        for (off = 2; off <= 30; off++) begin
            if (off == 16) resync_req = 1'b1;
            step();
            if (ttc_l1a) begin
                n_l1a++;
                check("clamp_pos", off, 4 * n_l1a);
            end
            if (off == 16) begin
                check("rsl1a_resync", ttc_resync, 1);
                check("rsl1a_l1a", ttc_l1a, 0);
                check("rsl1a_busy", l1a_busy, 0);
            end
        end
        resync_req = 1'b0;
        check("clamp_n3", n_l1a, 3);
        check("clamp_sent8", l1a_sent, 8);
`else
        l1a_period = 16'd4; l1a_count = 16'd0;
        l1a_start = 1'b1;
        step();
        l1a_start = 1'b0;
        n_l1a = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (ttc_l1a || l1a_busy) n_l1a++;
        end
        check("nol1a_strobes", n_l1a, 0);
        check("nol1a_sent", l1a_sent, 0);
`endif

        // Enable dropped during RESYNC
        step();
        resync_req = 1'b1;
        step();
        check("dis_rs_strobe", ttc_resync, 1);
        enable = 1'b0;
        step();
        resync_req = 1'b0;
        check("dis_bxn", bxn, 0);
        n_bx0 = 0; n_res = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (ttc_bx0) n_bx0++;
            if (ttc_resync) n_res++;
        end
        check("dis_no_bx0", n_bx0, 0);
        check("dis_no_resync", n_res, 0);
        check("dis_bxn_end", bxn, 0);

        // Asynchronous reset mid-run
        enable = 1'b1;
        step();
`ifdef TTC_GEN_L1A_EN
        l1a_period = 16'd4; l1a_count = 16'd0;
        l1a_start = 1'b1;
        step();
        l1a_start = 1'b0;
`endif
        for (int c = 0; c < 10; c++) step();
        check("pre_arst_bxn", bxn, 11 - (`ifdef TTC_GEN_L1A_EN 0 `else 1 `endif));
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_bxn", bxn, 0);
        check("arst_busy", l1a_busy, 0);
        check("arst_sent", l1a_sent, 0);
        check("arst_l1a", ttc_l1a, 0);
        check("arst_bx0", ttc_bx0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
